// File: rtl/aes_pkg.sv
// Shared AES control definitions: key-size encodings, round counts and sequencer states.
// A reserved key_size decodes to the AES-128 round count.
package aes_pkg;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;
    localparam logic [1:0] KS_RSV = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_t;

    function automatic logic [3:0] nr_of(input logic [1:0] key_size);
        logic [3:0] nr;
        case (key_size)
            KS_192:  nr = NR_192;
            KS_256:  nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Steps the iterative AES round core: load, Nr-1 rounds, final round, then holds the result.
// Latency Nr+2 cycles from command handshake to out_valid; out_valid held until out_ready (abort drops it).
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int RK_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_ready,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      key_size,
    input  logic            dir,
    input  logic            abort,
    output logic            core_load,
    output logic            core_round_en,
    output logic            last_round,
    output logic [RK_W-1:0] rk_sel,
    output logic [RK_W-1:0] round_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam logic [RK_W-1:0] ONE = RK_W'(1);

    seq_state_t      state;
    logic [RK_W-1:0] rnd;
    logic [RK_W-1:0] nr_q;
    logic            dir_q;
    logic [RK_W-1:0] cmd_nr;
    logic [RK_W-1:0] rnd_nxt;

    // Decryption walks the expanded key from the top down; r never exceeds Nr.
    function automatic logic [RK_W-1:0] rk_of(input logic d,
                                              input logic [RK_W-1:0] nr,
                                              input logic [RK_W-1:0] r);
        return d ? (nr - r) : r;
    endfunction

    assign cmd_nr      = RK_W'(nr_of(key_size));
    assign rnd_nxt     = rnd + ONE;
    assign start_ready = (state == ST_IDLE) && key_ready;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rnd           <= '0;
            nr_q          <= RK_W'(NR_128);
            dir_q         <= 1'b0;
            core_load     <= 1'b0;
            core_round_en <= 1'b0;
            last_round    <= 1'b0;
            out_valid     <= 1'b0;
            rk_sel        <= '0;
            round_idx     <= '0;
        end else begin
            core_load     <= 1'b0;
            core_round_en <= 1'b0;
            last_round    <= 1'b0;
            out_valid     <= 1'b0;
            rk_sel        <= '0;
            round_idx     <= '0;

            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                rnd   <= '0;
                nr_q  <= RK_W'(NR_128);
                dir_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_valid && key_ready) begin
                            state     <= ST_LOAD;
                            nr_q      <= cmd_nr;
                            dir_q     <= dir;
                            rnd       <= '0;
                            core_load <= 1'b1;
                            rk_sel    <= dir ? cmd_nr : '0;
                        end
                    end
                    ST_LOAD: begin
                        state         <= ST_ROUND;
                        rnd           <= ONE;
                        round_idx     <= ONE;
                        core_round_en <= 1'b1;
                        rk_sel        <= rk_of(dir_q, nr_q, ONE);
                    end
                    ST_ROUND: begin
                        core_round_en <= 1'b1;
                        if (rnd == (nr_q - ONE)) begin
                            state      <= ST_FINAL;
                            rnd        <= nr_q;
                            round_idx  <= nr_q;
                            last_round <= 1'b1;
                            rk_sel     <= dir_q ? '0 : nr_q;
                        end else begin
                            rnd       <= rnd_nxt;
                            round_idx <= rnd_nxt;
                            rk_sel    <= rk_of(dir_q, nr_q, rnd_nxt);
                        end
                    end
                    ST_FINAL: begin
                        state     <= ST_HOLD;
                        rnd       <= '0;
                        out_valid <= 1'b1;
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            state <= ST_IDLE;
                        end else begin
                            out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        rnd   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed checks of the AES round sequencer: per-cycle control decode for each key size and
// direction, output stall in HOLD, abort (mid-round and in HOLD), and asynchronous reset.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_ready;
    logic       start_valid;
    logic       start_ready;
    logic [1:0] key_size;
    logic       dir;
    logic       abort;
    logic       core_load;
    logic       core_round_en;
    logic       last_round;
    logic [3:0] rk_sel;
    logic [3:0] round_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    aes_round_sequencer #(.RK_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_ready     (key_ready),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .key_size      (key_size),
        .dir           (dir),
        .abort         (abort),
        .core_load     (core_load),
        .core_round_en (core_round_en),
        .last_round    (last_round),
        .rk_sel        (rk_sel),
        .round_idx     (round_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // {busy, core_load, core_round_en, last_round, out_valid, rk_sel, round_idx}
    logic [12:0] obs;
    assign obs = {busy, core_load, core_round_en, last_round, out_valid, rk_sel, round_idx};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected control vector k cycles after the accepting edge.
    function automatic logic [12:0] expv(input int k, input int nr, input bit d);
        logic [3:0] n4;
        logic [3:0] r4;
        n4 = 4'(nr);
        r4 = 4'(k - 1);
        if (k == 1)
            return {5'b11000, (d ? n4 : 4'd0), 4'd0};
        else if (k <= nr)
            return {5'b10100, (d ? 4'(n4 - r4) : r4), r4};
        else if (k == nr + 1)
            return {5'b10110, (d ? 4'd0 : n4), n4};
        else
            return {5'b10001, 8'd0};
    endfunction

    // kill_k: 0 = run to completion; otherwise abort (kill_rst=0) or reset (kill_rst=1) after cycle kill_k.
    task automatic do_op(input string name, input logic [1:0] ks, input bit d, input int nr,
                         input int hold, input int kill_k, input bit kill_rst);
        start_valid = 1'b1;
        key_size    = ks;
        dir         = d;
        out_ready   = (hold == 0);
        chk({name, ".start_ready"}, 32'(start_ready), 32'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        key_size    = ~ks;
        dir         = ~d;
        for (int k = 1; k <= nr + 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s.k%0d", name, k), 32'(obs), 32'(expv(k, nr, d)));
            if (k == kill_k) begin
                if (kill_rst) begin
                    rst = 1'b1;
                    #1;
                    chk({name, ".async_rst"}, 32'({obs, start_ready}), 32'h1);
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    abort     = 1'b1;
                    out_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk({name, ".after_abort"}, 32'({obs, start_ready}), 32'h1);
                end
                out_ready = 1'b0;
                return;
            end
        end
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("%s.hold%0d", name, i), 32'({out_valid, busy, start_ready}), 32'b110);
        end
        start_valid = 1'b0;
        out_ready   = 1'b1;
        @(negedge clk);
        chk({name, ".idle"}, 32'({obs, start_ready}), 32'h1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        key_ready   = 1'b1;
        start_valid = 1'b0;
        key_size    = 2'b00;
        dir         = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.outputs", 32'(obs), 32'd0);
        chk("reset.start_ready", 32'(start_ready), 32'd1);

        key_ready   = 1'b0;
        start_valid = 1'b1;
        #1;
        chk("nokey.start_ready", 32'(start_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("nokey.not_accepted", 32'(obs), 32'd0);
        start_valid = 1'b0;
        key_ready   = 1'b1;

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'({obs, start_ready}), 32'h1);

        do_op("enc256", 2'b10, 1'b0, 14, 0, 0, 1'b0);
        do_op("dec128", 2'b00, 1'b1, 10, 0, 0, 1'b0);
        do_op("enc192_stall", 2'b01, 1'b0, 12, 5, 0, 1'b0);
        do_op("dec192", 2'b01, 1'b1, 12, 0, 0, 1'b0);
        do_op("enc192_abort", 2'b01, 1'b0, 12, 0, 6, 1'b0);
        do_op("enc128_after_abort", 2'b00, 1'b0, 10, 0, 0, 1'b0);
        do_op("dec256_hold_abort", 2'b10, 1'b1, 14, 0, 16, 1'b0);
        do_op("rsv_as_128", 2'b11, 1'b0, 10, 0, 0, 1'b0);
        do_op("rsv_rst", 2'b11, 1'b1, 10, 0, 4, 1'b1);
        chk("post_rst.idle", 32'({obs, start_ready}), 32'h1);
        do_op("enc128_after_rst", 2'b00, 1'b0, 10, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM for the iterative AES datapath. It accepts one block-encrypt or block-decrypt command and steps the single-round core through the initial AddRoundKey, Nr−1 full rounds and the final round. For each step it drives the round-key index into the 1920-bit expanded-key store. It then holds the result valid until it is consumed. It sits between the command source (switch/host logic) and the round core plus key-expansion result, and replaces free-running per-round enables.

## Interface
Parameters:
- RK_W, 4, width of round index / round-key select (max index 14)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_ready  in  1  expanded key is valid for the current key
- start_valid  in  1  command request
- start_ready  out  1  sequencer can accept a command
- key_size  in  2  00=128 (Nr=10), 01=192 (Nr=12), 10=256 (Nr=14), 11=reserved, treated as 128
- dir  in  1  0=encrypt, 1=decrypt
- abort  in  1  synchronous flush of the current operation
- core_load  out  1  core loads input block XOR rk[rk_sel]
- core_round_en  out  1  core performs one round using rk[rk_sel]
- last_round  out  1  qualifies core_round_en; omit MixColumns/InvMixColumns
- rk_sel  out  RK_W  round-key index into the expanded key
- round_idx  out  RK_W  current round number, 0 during load
- out_valid  out  1  result block valid in core
- out_ready  in  1  consumer takes result
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, LOAD, ROUND, FINAL, HOLD.
- IDLE:
  - start_ready = key_ready.
  - The command is accepted on start_valid & start_ready.
  - key_size → Nr and dir are latched on acceptance; later input changes are ignored.
  - → LOAD.
- LOAD:
  - core_load=1, round_idx=0.
  - rk_sel = 0 (enc) or Nr (dec).
  - → ROUND.
- ROUND:
  - core_round_en=1 with round_idx r = 1..Nr−1, incremented each cycle.
  - rk_sel = r (enc) or Nr−r (dec).
  - → FINAL after r = Nr−1.
- FINAL:
  - core_round_en=1, last_round=1, round_idx=Nr.
  - rk_sel = Nr (enc) or 0 (dec).
  - → HOLD.
- HOLD:
  - out_valid=1 until out_ready is sampled high, then → IDLE.
  - out_valid does not drop without a handshake, except on abort.
- abort:
  - From any non-IDLE state → IDLE on the next edge.
  - No out_valid is produced and the latched command is discarded.
  - abort in IDLE has no effect.
- Priority: abort beats the out_ready handshake in HOLD. The result is considered dropped.
- key_ready falling mid-operation does not stop the sequence. Key stability during an operation is the key-expansion owner's obligation.
- All control outputs other than those listed per state are 0.
- Round counter: 4-bit unsigned, never exceeds 14. rk_sel arithmetic (Nr−r) is 4-bit with no wrap, since r ≤ Nr.

## Timing
- Reset:
  - state=IDLE, round counter=0, latched Nr=10, dir=0.
  - All outputs 0; start_ready follows key_ready combinationally from IDLE.
- All outputs are decoded from registered state and counter; there is no combinational path from start_valid or out_ready to any output.
- Handshake at edge T:
  - LOAD at T+1.
  - ROUND at T+2..T+Nr.
  - FINAL at T+Nr+1.
  - out_valid first high at T+Nr+2.
  - Resulting latency: 12 / 14 / 16 cycles for 128 / 192 / 256.
- Back-to-back: the earliest next acceptance is the cycle after the HOLD handshake (one IDLE bubble).
- Reset asserted mid-operation forces the reset values immediately (asynchronously); there is no out_valid for the interrupted block.

## Structure
- Shared package aes_pkg:
  - key-size encoding constants.
  - NR_128/NR_192/NR_256 (10/12/14).
  - State enum type.
  - Function nr_of(key_size), which maps 11 → 10.
- Single module; no sub-module. A separate aes_rk_index is not warranted: the rk_sel mux is one subtract and one mux.

## Test plan
- Reset with key_ready=1, then idle: all outputs 0 except start_ready=1. Drop key_ready → start_ready=0 and a pending start_valid is not accepted.
- Encrypt, key_size=10, out_ready=1:
  - core_load with rk_sel=0 at T+1.
  - rk_sel 1..13 on core_round_en.
  - last_round with rk_sel=14 at T+15.
  - out_valid at T+16 for one cycle.
- Decrypt, key_size=00: rk_sel sequence 10,9,…,1,0; last_round only on rk_sel=0; out_valid at T+12.
- out_ready held low 5 cycles in HOLD: out_valid stays high for 5 cycles; start_valid during this time is not accepted.
- abort at T+6 of a 192-bit encrypt: busy=0 at T+7, no out_valid. A new command is accepted at T+7 if start_valid and key_ready are high.
- key_size=11: behaves as 128 (out_valid at T+12). rst pulsed at T+4: outputs return to reset values within the reset cycle.
